// File: rtl/sobel_pkg.sv
// Shared types and arithmetic helpers for the sobel_stream 3x3 gradient edge detector.
package sobel_pkg;

   typedef enum logic [1:0] {
      MODE_SOBEL   = 2'd0,
      MODE_PREWITT = 2'd1,
      MODE_THRESH  = 2'd2
   } mode_t;

   function automatic int grad_width(input int word_size);
      return word_size + 3;
   endfunction

   // The reserved encoding 2'b11 falls back to plain Sobel.
   function automatic mode_t decode_mode(input logic [1:0] m);
      mode_t r;
      case (m)
         2'b01:   r = MODE_PREWITT;
         2'b10:   r = MODE_THRESH;
         default: r = MODE_SOBEL;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] sat_u(input logic [31:0] v, input int width);
      logic [31:0] lim;
      lim = (32'd1 << width) - 32'd1;
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/sobel_stream_line_window.sv
// Two circular line buffers addressed by column plus the 3x3 sliding window they feed.
module line_window #(
   parameter int WORD_SIZE = 8,
   parameter int IMG_WIDTH = 640
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               en_i,
   input  logic [$clog2(IMG_WIDTH)-1:0]       col_i,
   input  logic [WORD_SIZE-1:0]               pixel_i,
   output logic [2:0][2:0][WORD_SIZE-1:0]     win_o
);

   logic [WORD_SIZE-1:0]           lb0_q [IMG_WIDTH];
   logic [WORD_SIZE-1:0]           lb1_q [IMG_WIDTH];
   logic [2:0][2:0][WORD_SIZE-1:0] win_q;

   // Line RAM: lb1 holds the previous line, lb0 the one before it; no reset.
   always_ff @(posedge clock) begin
      if (en_i) begin
         lb1_q[col_i] <= pixel_i;
         lb0_q[col_i] <= lb1_q[col_i];
      end
   end

   // Window shifts left one column per accepted pixel; row 0 is the oldest line.
   always_ff @(posedge clock) begin
      if (reset) begin
         win_q <= {(9*WORD_SIZE){1'b0}};
      end else if (en_i) begin
         for (int i = 0; i < 3; i++) begin
            win_q[i][0] <= win_q[i][1];
            win_q[i][1] <= win_q[i][2];
         end
         win_q[0][2] <= lb0_q[col_i];
         win_q[1][2] <= lb1_q[col_i];
         win_q[2][2] <= pixel_i;
      end
   end

   assign win_o = win_q;

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel/Prewitt/threshold edge detector with fixed 3-register latency.
module sobel_stream
   import sobel_pkg::*;
#(
   parameter int WORD_SIZE  = 8,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [WORD_SIZE-1:0] in_pixel,
   input  logic                 in_sof,
   input  logic [1:0]           mode,
   input  logic [WORD_SIZE-1:0] threshold,
   output logic                 out_valid,
   output logic [WORD_SIZE-1:0] out_pixel,
   output logic                 out_sof,
   output logic                 out_eol
);

   localparam int GW = grad_width(WORD_SIZE);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   logic [CW-1:0]          col_q, col_d, pos_col_s;
   logic [RW-1:0]          row_q, row_d, pos_row_s;
   mode_t                  mode_q, cur_mode_s, mode1_q, mode2_q;
   logic [WORD_SIZE-1:0]   thr_q, cur_thr_s, thr1_q, thr2_q;
   logic                   v1_q, sof1_q, eol1_q, zero1_q;
   logic                   v2_q, sof2_q, eol2_q, zero2_q;
   logic                   k_shift_s;
   logic [GW-1:0]          pos_x_d, neg_x_d, pos_y_d, neg_y_d;
   logic [GW-1:0]          pos_x_q, neg_x_q, pos_y_q, neg_y_q;
   logic [GW-1:0]          abs_x_s, abs_y_s, grad_s;
   logic [31:0]            sob_w_s, pre_w_s;
   logic [WORD_SIZE-1:0]   sob_s, pre_s, res_s, pix_d;
   logic [2:0][2:0][WORD_SIZE-1:0] win_s;
   logic                   sig_unused_s;

   function automatic logic [GW-1:0] ext(input logic [WORD_SIZE-1:0] v);
      return GW'(v);
   endfunction

   // Position of the pixel on the input this cycle; sof restarts the raster.
   always_comb begin
      if (in_sof) begin
         pos_col_s  = CW'(0);
         pos_row_s  = RW'(0);
         cur_mode_s = decode_mode(mode);
         cur_thr_s  = threshold;
      end else begin
         pos_col_s  = col_q;
         pos_row_s  = row_q;
         cur_mode_s = mode_q;
         cur_thr_s  = thr_q;
      end
      if (pos_col_s == COL_LAST) begin
         col_d = CW'(0);
         if (pos_row_s == ROW_LAST) begin
            row_d = RW'(0);
         end else begin
            row_d = pos_row_s + RW'(1);
         end
      end else begin
         col_d = pos_col_s + CW'(1);
         row_d = pos_row_s;
      end
   end

   // Raster counters and per-frame mode/threshold latch, advanced only by accepted pixels.
   always_ff @(posedge clock) begin
      if (reset) begin
         col_q  <= CW'(0);
         row_q  <= RW'(0);
         mode_q <= MODE_SOBEL;
         thr_q  <= {WORD_SIZE{1'b0}};
      end else if (in_valid) begin
         col_q  <= col_d;
         row_q  <= row_d;
         mode_q <= cur_mode_s;
         thr_q  <= cur_thr_s;
      end
   end

   line_window #(
      .WORD_SIZE (WORD_SIZE),
      .IMG_WIDTH (IMG_WIDTH)
   ) u_window (
      .clock   (clock),
      .reset   (reset),
      .en_i    (in_valid),
      .col_i   (pos_col_s),
      .pixel_i (in_pixel),
      .win_o   (win_s)
   );

   // Stage 1 sideband; mode travels with the pixel so frame boundaries stay clean.
   always_ff @(posedge clock) begin
      if (reset) begin
         v1_q    <= 1'b0;
         sof1_q  <= 1'b0;
         eol1_q  <= 1'b0;
         zero1_q <= 1'b0;
         mode1_q <= MODE_SOBEL;
         thr1_q  <= {WORD_SIZE{1'b0}};
      end else begin
         v1_q    <= in_valid;
         sof1_q  <= in_valid & in_sof;
         eol1_q  <= in_valid & (pos_col_s == COL_LAST);
         zero1_q <= (pos_row_s < RW'(2)) || (pos_col_s < CW'(2));
         mode1_q <= cur_mode_s;
         thr1_q  <= cur_thr_s;
      end
   end

   // Positive and negative partial sums of gx and gy; k is 1 for Prewitt, 2 otherwise.
   always_comb begin
      if (mode1_q == MODE_PREWITT) begin
         k_shift_s = 1'b0;
      end else begin
         k_shift_s = 1'b1;
      end
      pos_x_d = ext(win_s[0][2]) + (ext(win_s[1][2]) << k_shift_s) + ext(win_s[2][2]);
      neg_x_d = ext(win_s[0][0]) + (ext(win_s[1][0]) << k_shift_s) + ext(win_s[2][0]);
      pos_y_d = ext(win_s[2][0]) + (ext(win_s[2][1]) << k_shift_s) + ext(win_s[2][2]);
      neg_y_d = ext(win_s[0][0]) + (ext(win_s[0][1]) << k_shift_s) + ext(win_s[0][2]);
   end

   // Stage 2 registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         v2_q    <= 1'b0;
         sof2_q  <= 1'b0;
         eol2_q  <= 1'b0;
         zero2_q <= 1'b0;
         mode2_q <= MODE_SOBEL;
         thr2_q  <= {WORD_SIZE{1'b0}};
         pos_x_q <= GW'(0);
         neg_x_q <= GW'(0);
         pos_y_q <= GW'(0);
         neg_y_q <= GW'(0);
      end else begin
         v2_q    <= v1_q;
         sof2_q  <= sof1_q;
         eol2_q  <= eol1_q;
         zero2_q <= zero1_q;
         mode2_q <= mode1_q;
         thr2_q  <= thr1_q;
         pos_x_q <= pos_x_d;
         neg_x_q <= neg_x_d;
         pos_y_q <= pos_y_d;
         neg_y_q <= neg_y_d;
      end
   end

   // Magnitude, scaling and saturation; incomplete windows are forced to zero.
   always_comb begin
      abs_x_s = (pos_x_q >= neg_x_q) ? (pos_x_q - neg_x_q) : (neg_x_q - pos_x_q);
      abs_y_s = (pos_y_q >= neg_y_q) ? (pos_y_q - neg_y_q) : (neg_y_q - pos_y_q);
      grad_s  = abs_x_s + abs_y_s;
      sob_w_s = sat_u(32'(grad_s >> 2), WORD_SIZE);
      pre_w_s = sat_u(32'(grad_s >> 1), WORD_SIZE);
      sob_s   = sob_w_s[WORD_SIZE-1:0];
      pre_s   = pre_w_s[WORD_SIZE-1:0];
      case (mode2_q)
         MODE_PREWITT: res_s = pre_s;
         MODE_THRESH:  res_s = (sob_s >= thr2_q) ? {WORD_SIZE{1'b1}} : {WORD_SIZE{1'b0}};
         default:      res_s = sob_s;
      endcase
      if (zero2_q) begin
         pix_d = {WORD_SIZE{1'b0}};
      end else begin
         pix_d = res_s;
      end
   end

   assign sig_unused_s = ^{win_s[1][1], sob_w_s[31:WORD_SIZE], pre_w_s[31:WORD_SIZE]};

   // Output register; pixel value holds while no valid output is presented.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_pixel <= {WORD_SIZE{1'b0}};
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
      end else begin
         out_valid <= v2_q;
         out_sof   <= v2_q & sof2_q;
         out_eol   <= v2_q & eol2_q;
         if (v2_q) begin
            out_pixel <= pix_d;
         end
      end
   end

endmodule

// File: doc/sobel_stream.md
Name: sobel_stream

Overview:
- Streaming 3x3 gradient edge detector for raster-scan pixel streams, with valid qualification and frame/line markers.
- Image width and height are parametrised. The line buffers are sized by IMG_WIDTH.
- Kernel is selectable per frame: Sobel magnitude, Prewitt magnitude, or binary threshold.
- Sits between the pixel source (camera/ROM reader) and the downstream image sink. There is no back-pressure; the sink must always accept.

Parameters:
- WORD_SIZE, 8, pixel bit width (input and output).
- IMG_WIDTH, 640, pixels per line (>=3).
- IMG_HEIGHT, 480, lines per frame (>=3).

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_pixel is valid this cycle.
- in_pixel  in  WORD_SIZE  raster-order pixel.
- in_sof  in  1  first pixel of frame; sampled only when in_valid=1.
- mode  in  2  00 Sobel, 01 Prewitt, 10 Sobel threshold, 11 reserved (treated as 00).
- threshold  in  WORD_SIZE  binarisation level for mode 10.
- out_valid  out  1  out_pixel is valid.
- out_pixel  out  WORD_SIZE  gradient result.
- out_sof  out  1  marks the output matching an in_sof input.
- out_eol  out  1  marks the output matching input column IMG_WIDTH-1.

Behaviour:
- Reset: out_valid, out_pixel, out_sof, out_eol = 0. Column/row counters = 0. All pipeline valids = 0. Line-buffer RAM is not reset.
- Reset mid-operation discards all in-flight pixels. The next accepted pixel is treated as row 0, column 0.
- Counters advance only on in_valid:
  - col counts 0..IMG_WIDTH-1, then wraps to 0 and row increments.
  - row wraps to 0 after IMG_HEIGHT-1.
  - in_sof=1 with in_valid forces this pixel to (row 0, col 0), including mid-frame.
- mode and threshold are latched on an in_valid & in_sof cycle and held for the whole frame. Before the first sof, the reset value is mode 00, threshold 0.
- Window: two line buffers of IMG_WIDTH words plus a 3x3 window register. Indexing is w[i][j]:
  - i = 0 top (oldest line), i = 2 current line.
  - j = 0 left, j = 2 current column.
  - Window, line buffers and counters update only on in_valid. Gaps in in_valid therefore do not change the result sequence.
- Output position: each accepted input at (r,c) produces exactly one output, the gradient centred on (r-1,c-1).
  - If r<2 or c<2 the window is incomplete and the output is 0.
  - This deliberate one-pixel shift is required; there is no end-of-frame flush.
- Arithmetic, with k=2 for Sobel/threshold and k=1 for Prewitt:
  - gx = (w0,2 + k*w1,2 + w2,2) - (w0,0 + k*w1,0 + w2,0)
  - gy = (w2,0 + k*w2,1 + w2,2) - (w0,0 + k*w0,1 + w0,2)
  - G = |gx| + |gy|, computed in WORD_SIZE+3 bits with no overflow.
  - Sobel: out = min(G>>2, 2^WORD_SIZE-1).
  - Prewitt: out = min(G>>1, 2^WORD_SIZE-1).
  - Threshold: out = all-ones if (G>>2 saturated) >= threshold, else 0.
- Pipeline:
  - Stage 1: window update.
  - Stage 2: registered positive/negative partial sums plus propagated valid/sof/eol/zero-flag.
  - Stage 3: abs, sum, scale, saturate into the output register.
- Latency: an input accepted at clock edge n appears at out_valid after edge n+2, i.e. exactly 3 registers. Latency is fixed and independent of in_valid gaps.
- out_valid is a registered copy of the delayed in_valid. out_pixel is held when out_valid=0.
- Back-to-back frames without idle cycles must work. A new frame's row 0/1 outputs are 0 regardless of stale line-buffer contents.

Decomposition:
- Package sobel_pkg:
  - mode_t enum {MODE_SOBEL, MODE_PREWITT, MODE_THRESH}.
  - Function grad_width(WORD_SIZE) = WORD_SIZE+3.
  - Saturation helper function.
- Sub-module line_window #(WORD_SIZE, IMG_WIDTH):
  - Contains the two line buffers (circular RAM addressed by col) and the 3x3 window register.
  - Advances on an enable input (in_valid).
  - Outputs the window as a packed 3x3 array.
- sobel_stream owns the counters, mode latch, arithmetic pipeline and markers.

Test Plan:
- Constant image, 8x6, all pixels 100, any mode: 48 outputs, all 0. out_sof on the first output, out_eol on every 8th. First out_valid 3 cycles after the first in_valid.
- Vertical step, 8x6, cols 0-3 = 0, cols 4-7 = 255, Sobel: output rows 2-5 give 255 at cols 4 and 5, 0 elsewhere. Rows 0-1 and cols 0-1 are 0. Prewitt gives the same pattern (382 saturates to 255).
- Step 0|40, mode 10: threshold 40 gives 255 at cols 4,5. threshold 41 gives all zeros. Sobel mode gives 40 at cols 4,5.
- Diagonal saturation: window with top row and left column 0, rest 255 → G >= 1020. Sobel out 255; no wrap-around to small values.
- Random in_valid gaps (50% duty) on the vertical-step frame: the out_valid-qualified sequence is identical to the gap-free run.
- Mid-frame sof at (3,5), then reset asserted mid-frame: restarted frame rows 0-1 output 0, and the later rows match the golden model. After reset, out_valid stays 0 until 3 cycles after the next in_valid.
